// File: rtl/hash_word_loader.sv
// hash_word_loader
//   Builds a 128-bit hash value from eight 16-bit switch words. Each debounced
//   press of btn_load commits one word. The page output drives the display
//   selector directly, so the word being entered is shown while it is entered.
//   Page encoding: 0 = normal view, n = 1..8 = word n = hash bits [16n-1:16n-16].
//
// Ports
//   clk           in   1    system clock
//   rst_n         in   1    synchronous active-low reset
//   start         in   1    single-cycle pulse: begin or restart entry
//   btn_load      in   1    raw push-button: commit the registered switch word
//   btn_clear     in   1    raw push-button: abort entry and zero the hash
//   sw_word       in   16   raw switch word
//   hash_word_out out  128  assembled hash value
//   page          out  4    display page, 0..8
//   busy          out  1    high while entry is in progress
//   load_done     out  1    one-cycle pulse when the last word is committed
//
// Parameters
//   DEBOUNCE_CYCLES  stable synchronized samples needed before a debounced
//                    level changes (minimum 2)
//   NUM_WORDS        words per hash, must be 8
//
// Build option
//   HASH_LOADER_READBACK_EN: once entry is complete, further load presses step
//   page 1..8 and wrap 8->1 so each stored word can be reviewed on the
//   display. The hash itself is not touched. Without the macro, load presses
//   in the complete state are ignored and page stays 0.

module hash_word_loader #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_WORDS       = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         btn_load,
    input  logic         btn_clear,
    input  logic [15:0]  sw_word,
    output logic [127:0] hash_word_out,
    output logic [3:0]   page,
    output logic         busy,
    output logic         load_done
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        DONE  = 2'd2
    } state_t;

    // ---------------------------------------------------------------
    // Button conditioning. Index 0 = load button, index 1 = clear button.
    // ---------------------------------------------------------------
    logic [1:0]    raw_btn;
    logic [1:0]    sync1_q, sync1_d;
    logic [1:0]    sync2_q, sync2_d;
    logic [1:0]    level_q, level_d;
    logic [1:0]    seen_q, seen_d;    // level delayed by one cycle, for edge detect
    logic [1:0]    rise;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];

    assign raw_btn = {btn_clear, btn_load};

    always_comb begin
        sync1_d = raw_btn;
        sync2_d = sync1_q;
        level_d = level_q;
        seen_d  = level_q;
        for (int b = 0; b < 2; b++) begin
            cnt_d[b] = cnt_q[b];
            if (sync2_q[b] == level_q[b]) begin
                // Sample agrees with the debounced level: any run is broken.
                cnt_d[b] = '0;
            end else if (cnt_q[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
                // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
                cnt_d[b]   = '0;
                level_d[b] = ~level_q[b];
            end else begin
                cnt_d[b] = cnt_q[b] + CW'(1);
            end
        end
    end

    // Pulse comes purely from flops, so it is one clean cycle wide. With a
    // raw rise just after edge 0, the level toggles at edge DEBOUNCE_CYCLES+2
    // and the FSM acts on the pulse at edge DEBOUNCE_CYCLES+3.
    assign rise = level_q & ~seen_q;

    // ---------------------------------------------------------------
    // Entry FSM and hash register
    // ---------------------------------------------------------------
    state_t        state_q, state_d;
    logic [3:0]    page_q, page_d;
    logic [127:0]  hash_q, hash_d;
    logic          load_done_q, load_done_d;
    logic [15:0]   sw_q, sw_d;
    logic          load_pulse;
    logic          clear_pulse;

    assign load_pulse  = rise[0];
    assign clear_pulse = rise[1];
    assign sw_d        = sw_word;

    always_comb begin
        state_d     = state_q;
        page_d      = page_q;
        hash_d      = hash_q;
        load_done_d = 1'b0;

        if (clear_pulse) begin
            state_d = IDLE;
            page_d  = 4'd0;
            hash_d  = '0;
        end else if (start) begin
            // Start also restarts an entry in progress and discards a
            // load pulse arriving on the same cycle.
            state_d = ENTRY;
            page_d  = 4'd1;
            hash_d  = '0;
        end else if (load_pulse) begin
            case (state_q)
                ENTRY: begin
                    for (int i = 0; i < NUM_WORDS; i++) begin
                        if (page_q == 4'(i + 1)) begin
                            hash_d[16*i +: 16] = sw_q;
                        end
                    end
                    if (page_q == 4'(NUM_WORDS)) begin
                        page_d      = 4'd0;
                        load_done_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        page_d = page_q + 4'd1;
                    end
                end
                DONE: begin
`ifdef HASH_LOADER_READBACK_EN
                    // Review mode: 0->1..8 then wrap to 1, never back to 0.
                    if (page_q == 4'(NUM_WORDS)) begin
                        page_d = 4'd1;
                    end else begin
                        page_d = page_q + 4'd1;
                    end
`else
                    page_d = 4'd0;
`endif
                end
                default: begin
                    // IDLE: load presses have no effect.
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            seen_q      <= '0;
            for (int b = 0; b < 2; b++) begin
                cnt_q[b] <= '0;
            end
            sw_q        <= '0;
            state_q     <= IDLE;
            page_q      <= 4'd0;
            hash_q      <= '0;
            load_done_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            seen_q      <= seen_d;
            for (int b = 0; b < 2; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
            sw_q        <= sw_d;
            state_q     <= state_d;
            page_q      <= page_d;
            hash_q      <= hash_d;
            load_done_q <= load_done_d;
        end
    end

    assign hash_word_out = hash_q;
    assign page          = page_q;
    assign busy          = (state_q == ENTRY);
    assign load_done     = load_done_q;

endmodule

// File: doc/hash_word_loader.md
Name: hash_word_loader

Overview:
- Entry-side counterpart of the hash display path: assembles a 128-bit hash value from eight 16-bit words taken from board switches, one word per debounced button press.
- Drives a 4-bit page index with the same encoding the display selector consumes: 0 = normal view, 1..8 = word 1..8, where word n is bits [16n-1:16n-16].
- Sits between the switch/button inputs and the hash/PUF compare logic.
- Page output wires directly to the display selector's control input, so the word being entered is shown live.

Parameters:
- DEBOUNCE_CYCLES, default 1000000: consecutive stable synchronized samples required before a debounced button level changes. Minimum 2.
- NUM_WORDS, default 8: words per hash. Fixed at 8 for this revision; any other value is unsupported.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- start  input  1  single-cycle pulse from control logic; begins or restarts entry.
- btn_load  input  1  raw asynchronous push-button; commits the current switch word.
- btn_clear  input  1  raw asynchronous push-button; aborts entry and zeroes the hash.
- sw_word  input  16  raw switch value to commit.
- hash_word_out  output  128  assembled hash value.
- page  output  4  display page: 0 or 1..8.
- busy  output  1  high while in ENTRY.
- load_done  output  1  one-cycle pulse when word 8 is committed.

Behaviour:
- Reset (rst_n=0 at posedge):
  - hash_word_out=0, page=0, busy=0, load_done=0.
  - State IDLE.
  - Synchronizers, debounce counters and debounced levels all cleared to 0.
  - Reset mid-entry discards all partial words.
- Button conditioning (btn_load and btn_clear, independently):
  - 2-FF synchronizer, then a debounce counter.
  - Counter resets whenever the synchronized sample equals the debounced level.
  - Debounced level toggles when the counter reaches DEBOUNCE_CYCLES.
  - A debounced rising edge produces a registered one-cycle pulse.
  - Timing: raw rise held stable → pulse asserted exactly DEBOUNCE_CYCLES+3 posedges later.
  - Releases and glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- sw_word is registered once before capture; it must be stable while the button is held.
- FSM states: IDLE, ENTRY, DONE.
- IDLE:
  - page=0, busy=0.
  - start → ENTRY, page=1, hash_word_out=0.
  - Load pulses are ignored.
- ENTRY:
  - busy=1.
  - On a load pulse: hash_word_out[16*page-1 -: 16] <= registered sw_word on the same edge as the pulse, and page increments.
  - When page=8 and a load pulse arrives: word 8 is written, page<=0, load_done=1 for that cycle, state → DONE.
  - start while in ENTRY restarts entry: page=1, hash=0.
- DONE:
  - hash_word_out is held.
  - page=0, unless READBACK_EN is defined.
  - start → ENTRY (page=1, hash=0).
- Clear pulse, any state: hash=0, page=0 → IDLE.
- Priority on the same cycle: rst_n > clear pulse > start > load pulse.
- page never takes a value outside 0..8. There is no wrap from 8 to 9.

Optional Feature:
- Macro: HASH_LOADER_READBACK_EN.
- When defined:
  - In DONE, each load pulse steps page 0→1→2…→8→1 (wraps 8→1 and never returns to 0).
  - The display then reviews each stored word in turn.
  - hash_word_out is unchanged by these pulses.
  - load_done is not re-pulsed.
- When undefined: load pulses in DONE are ignored and page stays 0.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then hold rst_n high 10 cycles → hash=0, page=0, busy=0, load_done=0.
- start pulse; eight load presses, each held 10 cycles, with sw_word=16'h1111,16'h2222,…,16'h8888 → hash=128'h8888_7777_6666_5555_4444_3333_2222_1111, page sequence 1..8→0, exactly one load_done pulse, busy falls the same cycle.
- In ENTRY, btn_load glitch high for 3 cycles → no write; page unchanged. Held 10 cycles → write lands exactly 7 posedges after the raw rise.
- After 3 words (page=4), assert btn_clear for 10 cycles → hash=0, page=0, IDLE. A later load press does nothing.
- After 5 words, drive start and a load pulse on the same cycle → page=1, hash=0, no write.
- READBACK_EN defined: complete entry, then press load 9 times → page 1,2,…,8,1. Hash unchanged.
